// File: rtl/dmem_responder.sv
// Data-memory responder: word-organised array with byte-lane stores and right-aligned,
// one-cycle-latency loads feeding the MemWB stage.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned ADDR_BITS   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  input  logic                 req_write,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic [31:0]          req_wdata,
  input  logic [2:0]           req_funct3,
  output logic [31:0]          mem_data_out,
  output logic                 resp_valid,
  output logic [1:0]           resp_err
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_BITS:0] AddrLimit = (ADDR_BITS + 1)'(DEPTH_WORDS) << 2;

  typedef enum logic [1:0] {
    ErrOk       = 2'd0,
    ErrMisalign = 2'd1,
    ErrRange    = 2'd2,
    ErrFunct3   = 2'd3
  } err_e;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [1:0]      off;
  logic [IdxW-1:0] idx;
  logic [1:0]      size;
  err_e            err;
  logic [3:0]      be;
  logic [31:0]     wdata_rep;
  logic            wr_en;
  logic [31:0]     rd_word;
  logic [31:0]     shifted;
  logic [31:0]     load_data;

  logic [31:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic [1:0]  err_q, err_d;

  always_comb begin
    off  = req_addr[1:0];
    idx  = req_addr[IdxW+1:2];
    size = req_funct3[1:0];

    if ((req_funct3 inside {3'd3, 3'd6, 3'd7}) || (req_write && req_funct3[2])) begin
      err = ErrFunct3;
    end else if ({1'b0, req_addr} >= AddrLimit) begin
      err = ErrRange;
    end else if ((size == 2'd1 && off[0]) || (size == 2'd2 && off != 2'd0)) begin
      err = ErrMisalign;
    end else begin
      err = ErrOk;
    end

    // Lane data is replicated so the byte enables alone select the target lanes.
    case (size)
      2'd0: begin
        be        = 4'b0001 << off;
        wdata_rep = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        be        = 4'b0011 << off;
        wdata_rep = {2{req_wdata[15:0]}};
      end
      default: begin
        be        = 4'b1111;
        wdata_rep = req_wdata;
      end
    endcase

    wr_en = req_valid && req_write && (err == ErrOk);

    rd_word = mem_q[idx];
    shifted = rd_word >> {off, 3'b000};
    case (size)
      2'd0:    load_data = {24'b0, shifted[7:0]};
      2'd1:    load_data = {16'b0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  always_comb begin
    valid_d = req_valid;
    err_d   = 2'd0;
    data_d  = data_q;
    if (req_valid) begin
      err_d  = err;
      data_d = (!req_write && err == ErrOk) ? load_data : 32'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q  <= 32'b0;
      valid_q <= 1'b0;
      err_q   <= 2'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Array is not reset; reset only gates the write so a store during reset never lands.
  always_ff @(posedge clk) begin
    if (reset && wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem_q[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
        end
      end
    end
  end

  assign mem_data_out = data_q;
  assign resp_valid   = valid_q;
  assign resp_err     = err_q;

endmodule
